// File: rtl/counter_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// counter_seq_pkg
// Shared definitions for the display-counter sequencer: FSM state codes
// (also visible on the debug state output) and the rate_sel encodings.
// ----------------------------------------------------------------------------
package counter_seq_pkg;

  // FSM states; the numeric codes appear directly on the state output.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // rate_sel codes: 0 ticks every clock, 1..3 select the divider reloads.
  localparam logic [1:0] RATE_CLK  = 2'd0;
  localparam logic [1:0] RATE_DIV1 = 2'd1;
  localparam logic [1:0] RATE_DIV2 = 2'd2;
  localparam logic [1:0] RATE_DIV3 = 2'd3;

endpackage

// File: rtl/counter_sequencer_rate_divider.sv
// ----------------------------------------------------------------------------
// rate_divider
// Down-counter that produces a one-cycle tick every reload_val+1 active
// cycles. A reload_val of 0 ticks on every active cycle.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset (counter goes to 0)
//   load       load reload_val this cycle; no tick while loading
//   hold       freeze the counter; no tick while holding
//   reload_val value loaded on load and after each tick
//   tick       high for the active cycle in which the counter is at 0
// ----------------------------------------------------------------------------
module rate_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             hold,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] remaining;

  // reload_val is sampled at load and at each tick, so a rate change
  // takes effect at the next reload rather than mid-period.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= reload_val;
    end else if (!hold) begin
      if (remaining == '0) begin
        remaining <= reload_val;
      end else begin
        remaining <= remaining - DIV_W'(1);
      end
    end
  end

  assign tick = !load && !hold && (remaining == '0);

endmodule

// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
// Controller for the 8-bit display counter. Generates the counter's enable
// and clear strobes from start/stop/clear key pulses, paced by a selectable
// rate divider, and stops or wraps when the fed-back count reaches limit.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   start      one-cycle pulse: start, or resume from pause
//   stop       one-cycle pulse: pause
//   clear_req  one-cycle pulse: clear the counter and go idle
//   wrap       1 = restart from 0 after limit, 0 = stop at limit
//   rate_sel   0 = tick every clk, 1..3 = DIV1..DIV3 reloads
//   limit      terminal count value
//   count      current counter value (feedback)
//   cnt_en     counter advances on the next rising edge when high
//   cnt_clr_n  active-low counter clear, also low throughout reset
//   busy       high in RUN or PAUSE
//   done       high in DONE
//   state      current FSM state code (debug)
// ----------------------------------------------------------------------------
module counter_sequencer #(
  parameter int DIV_W = 26,
  parameter int DIV1  = 49_999_999,
  parameter int DIV2  = 24_999_999,
  parameter int DIV3  = 12_499_999
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_req,
  input  logic       wrap,
  input  logic [1:0] rate_sel,
  input  logic [7:0] limit,
  input  logic [7:0] count,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  import counter_seq_pkg::*;

  state_t           cur_state;
  logic             next_run;
  logic             clr_pulse_n;
  logic [DIV_W-1:0] reload_val;
  logic             tick;
  logic             div_load;
  logic             div_hold;
  logic [7:0]       next_count;
  logic             at_limit;

  always_comb begin
    reload_val = '0;
    case (rate_sel)
      RATE_CLK:  reload_val = '0;
      RATE_DIV1: reload_val = DIV_W'(DIV1);
      RATE_DIV2: reload_val = DIV_W'(DIV2);
      RATE_DIV3: reload_val = DIV_W'(DIV3);
      default:   reload_val = '0;
    endcase
  end

  // The divider is armed while passing through CLEAR and only runs in RUN,
  // so PAUSE keeps the partial period for resume.
  assign div_load = (cur_state == ST_CLEAR);
  assign div_hold = (cur_state != ST_RUN);

  rate_divider #(
    .DIV_W(DIV_W)
  ) u_rate_divider (
    .clk       (clk),
    .clr       (clr),
    .load      (div_load),
    .hold      (div_hold),
    .reload_val(reload_val),
    .tick      (tick)
  );

  // cnt_en is registered, so an increment granted last cycle lands on the
  // same edge this cycle's decision is taken. Comparing count plus that
  // in-flight increment keeps back-to-back ticks from overshooting limit.
  assign next_count = count + {7'd0, cnt_en};
  assign at_limit   = (next_count == limit);

  // Priority every cycle is clear_req, then stop, then start/tick.
  // busy and done are updated on the transitions that change them.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur_state   <= ST_IDLE;
      next_run    <= 1'b0;
      cnt_en      <= 1'b0;
      clr_pulse_n <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt_en      <= 1'b0;
      clr_pulse_n <= 1'b1;
      case (cur_state)
        ST_IDLE: begin
          if (clear_req) begin
            cur_state   <= ST_CLEAR;
            next_run    <= 1'b0;
            clr_pulse_n <= 1'b0;
          end else if (start) begin
            cur_state   <= ST_CLEAR;
            next_run    <= 1'b1;
            clr_pulse_n <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clear_req || !next_run) begin
            cur_state <= ST_IDLE;
            next_run  <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cur_state <= ST_RUN;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            cur_state   <= ST_CLEAR;
            next_run    <= 1'b0;
            clr_pulse_n <= 1'b0;
            busy        <= 1'b0;
          end else if (stop) begin
            cur_state <= ST_PAUSE;
          end else if (tick) begin
            if (at_limit) begin
              if (wrap) begin
                cur_state   <= ST_CLEAR;
                next_run    <= 1'b1;
                clr_pulse_n <= 1'b0;
                busy        <= 1'b0;
              end else begin
                cur_state <= ST_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              cnt_en <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (clear_req) begin
            cur_state   <= ST_CLEAR;
            next_run    <= 1'b0;
            clr_pulse_n <= 1'b0;
            busy        <= 1'b0;
          end else if (start) begin
            cur_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (clear_req) begin
            cur_state   <= ST_CLEAR;
            next_run    <= 1'b0;
            clr_pulse_n <= 1'b0;
            done        <= 1'b0;
          end else if (start) begin
            cur_state   <= ST_CLEAR;
            next_run    <= 1'b1;
            clr_pulse_n <= 1'b0;
            done        <= 1'b0;
          end
        end
        default: begin
          cur_state <= ST_IDLE;
          next_run  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Only the reset term is combinational so the counter clears with reset.
  assign cnt_clr_n = clr & clr_pulse_n;
  assign state     = cur_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_sequencer
// Bench for counter_sequencer with an attached 8-bit counter. A cycle-level
// reference model tracks the expected state and enable from the behavioural
// rules; directed tables and sequences cover the documented scenarios, then
// randomized key pulses and setting changes are checked against the model.
// ----------------------------------------------------------------------------
module tb_counter_sequencer;

  localparam int T_DIV1 = 3;
  localparam int T_DIV2 = 5;
  localparam int T_DIV3 = 7;

  localparam int S_IDLE  = 0;
  localparam int S_CLEAR = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic       clk       = 1'b0;
  logic       clr       = 1'b0;
  logic       start     = 1'b0;
  logic       stop      = 1'b0;
  logic       clear_req = 1'b0;
  logic       wrap      = 1'b0;
  logic [1:0] rate_sel  = 2'd0;
  logic [7:0] limit     = 8'd0;
  logic [7:0] count     = 8'd0;
  logic       cnt_en;
  logic       cnt_clr_n;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  // reference model variables
  int m_state = S_IDLE;
  int m_go    = 0;
  int m_left  = 0;
  int m_pend  = 0;
  int m_en    = 0;

  typedef struct {
    bit       start;
    bit       stop;
    bit       clear_req;
    bit       wrap;
    bit [1:0] rate;
    bit [7:0] limit;
    bit [2:0] e_state;
    bit       e_en;
    bit       e_clr_n;
    bit       e_busy;
    bit       e_done;
    bit [7:0] e_count;
  } vec_t;

  vec_t tbl [9];

  counter_sequencer #(
    .DIV_W(26),
    .DIV1 (T_DIV1),
    .DIV2 (T_DIV2),
    .DIV3 (T_DIV3)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .stop     (stop),
    .clear_req(clear_req),
    .wrap     (wrap),
    .rate_sel (rate_sel),
    .limit    (limit),
    .count    (count),
    .cnt_en   (cnt_en),
    .cnt_clr_n(cnt_clr_n),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  // The display counter: synchronous clear, increments on cnt_en.
  always @(posedge clk) begin
    if (!cnt_clr_n) count <= 8'd0;
    else if (cnt_en) count <= count + 8'd1;
  end

  function automatic int reload_for(input int r);
    case (r)
      1:       return T_DIV1;
      2:       return T_DIV2;
      3:       return T_DIV3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_go    = 0;
    m_left  = 0;
    m_pend  = 0;
    m_en    = 0;
  endtask

  // m_pend is the value the counter will hold once every granted increment
  // has landed; m_left counts RUN cycles remaining before the next tick.
  task automatic model_step();
    int ns;
    bit tk;
    ns   = m_state;
    m_en = 0;
    case (m_state)
      S_IDLE: begin
        if (clear_req) begin ns = S_CLEAR; m_go = 0; end
        else if (start) begin ns = S_CLEAR; m_go = 1; end
      end
      S_CLEAR: begin
        m_left = reload_for(int'(rate_sel));
        m_pend = 0;
        if (clear_req) m_go = 0;
        ns = (m_go != 0) ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        tk     = (m_left == 0);
        m_left = tk ? reload_for(int'(rate_sel)) : m_left - 1;
        if (clear_req) begin ns = S_CLEAR; m_go = 0; end
        else if (stop) ns = S_PAUSE;
        else if (tk) begin
          if (m_pend == int'(limit)) begin
            if (wrap) begin ns = S_CLEAR; m_go = 1; end
            else ns = S_DONE;
          end else begin
            m_pend = (m_pend + 1) % 256;
            m_en   = 1;
          end
        end
      end
      S_PAUSE: begin
        if (clear_req) begin ns = S_CLEAR; m_go = 0; end
        else if (start) ns = S_RUN;
      end
      S_DONE: begin
        if (clear_req) begin ns = S_CLEAR; m_go = 0; end
        else if (start) begin ns = S_CLEAR; m_go = 1; end
      end
      default: ns = S_IDLE;
    endcase
    m_state = ns;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge
  // happen, advance the model, then compare at the next falling edge.
  task automatic apply_stimulus(input bit s, input bit p, input bit c,
                                input bit w, input bit [1:0] r, input bit [7:0] l);
    int exp_vec;
    int act_vec;
    start     = s;
    stop      = p;
    clear_req = c;
    wrap      = w;
    rate_sel  = r;
    limit     = l;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_vec = (m_state << 4) | (m_en << 3)
            | (((m_state != S_CLEAR) ? 1 : 0) << 2)
            | (((m_state == S_RUN || m_state == S_PAUSE) ? 1 : 0) << 1)
            | ((m_state == S_DONE) ? 1 : 0);
    act_vec = int'({state, cnt_en, cnt_clr_n, busy, done});
    check_output("model{state,en,clr_n,busy,done}", act_vec, exp_vec);
  endtask

  task automatic idle_step();
    apply_stimulus(1'b0, 1'b0, 1'b0, wrap, rate_sel, limit);
  endtask

  initial begin
    int gap;
    int first_pulse;
    int npulse;
    int k;
    int n3;
    int nbad;
    int nen;
    bit found;
    logic [7:0] seen [$];

    // table for the basic one-shot run to limit 5 at full rate
    tbl[0] = '{1, 0, 0, 0, 2'd0, 8'd5, 3'd1, 0, 0, 0, 0, 8'd0};
    tbl[1] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd2, 0, 1, 1, 0, 8'd0};
    tbl[2] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd2, 1, 1, 1, 0, 8'd0};
    tbl[3] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd2, 1, 1, 1, 0, 8'd1};
    tbl[4] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd2, 1, 1, 1, 0, 8'd2};
    tbl[5] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd2, 1, 1, 1, 0, 8'd3};
    tbl[6] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd2, 1, 1, 1, 0, 8'd4};
    tbl[7] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd4, 0, 1, 0, 1, 8'd5};
    tbl[8] = '{0, 0, 0, 0, 2'd0, 8'd5, 3'd4, 0, 1, 0, 1, 8'd5};

    // reset values while clr is held low
    #12;
    check_output("reset state", int'(state), 0);
    check_output("reset cnt_en", int'(cnt_en), 0);
    check_output("reset cnt_clr_n", int'(cnt_clr_n), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    #1;
    check_output("release cnt_clr_n", int'(cnt_clr_n), 1);
    @(negedge clk);

    // one-shot to 5
    $display("[TB] one-shot run to limit 5");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(tbl[i].start, tbl[i].stop, tbl[i].clear_req,
                     tbl[i].wrap, tbl[i].rate, tbl[i].limit);
      check_output($sformatf("tbl%0d state", i), int'(state), int'(tbl[i].e_state));
      check_output($sformatf("tbl%0d cnt_en", i), int'(cnt_en), int'(tbl[i].e_en));
      check_output($sformatf("tbl%0d cnt_clr_n", i), int'(cnt_clr_n), int'(tbl[i].e_clr_n));
      check_output($sformatf("tbl%0d busy", i), int'(busy), int'(tbl[i].e_busy));
      check_output($sformatf("tbl%0d done", i), int'(done), int'(tbl[i].e_done));
      check_output($sformatf("tbl%0d count", i), int'(count), int'(tbl[i].e_count));
    end
    nbad = 0;
    for (int i = 0; i < 20; i++) begin
      idle_step();
      if (count != 8'd5 || state != 3'd4) nbad++;
    end
    check_output("done hold 20 cycles", nbad, 0);

    // wrap at limit 3
    $display("[TB] wrap at limit 3");
    apply_stimulus(0, 0, 1, 0, 2'd0, 8'd3);
    idle_step();
    check_output("back to idle", int'(state), 0);
    seen.delete();
    seen.push_back(count);
    apply_stimulus(1, 0, 0, 1, 2'd0, 8'd3);
    n3 = 0;
    nbad = 0;
    for (int i = 0; i < 30; i++) begin
      idle_step();
      if (count != seen[$]) seen.push_back(count);
      if (!cnt_clr_n) begin
        if (count == 8'd3) n3++;
        else nbad++;
      end
    end
    check_output("wrap clear only at 3", nbad, 0);
    check_output("wrap clears seen >=2", (n3 >= 2) ? 1 : 0, 1);
    check_output("wrap seq length >=8", (seen.size() >= 8) ? 1 : 0, 1);
    if (seen.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        check_output($sformatf("wrap seq[%0d]", i), int'(seen[i]), i % 4);
    end

    // divided rate, pause and resume
    $display("[TB] divided rate with pause");
    apply_stimulus(0, 0, 1, 0, 2'd1, 8'd10);
    idle_step();
    apply_stimulus(1, 0, 0, 0, 2'd1, 8'd10);
    npulse = 0;
    first_pulse = 0;
    gap = 0;
    for (int i = 0; i < 40 && npulse < 2; i++) begin
      idle_step();
      if (cnt_en) begin
        npulse++;
        if (npulse == 1) first_pulse = i;
        else gap = i - first_pulse;
      end
    end
    check_output("two pulses seen", npulse, 2);
    check_output("pulse spacing", gap, T_DIV1 + 1);
    apply_stimulus(0, 1, 0, 0, 2'd1, 8'd10);
    check_output("paused state", int'(state), 3);
    check_output("paused busy", int'(busy), 1);
    nen = 0;
    for (int i = 0; i < 10; i++) begin
      idle_step();
      if (cnt_en) nen++;
    end
    check_output("no pulses in pause", nen, 0);
    apply_stimulus(1, 0, 0, 0, 2'd1, 8'd10);
    k = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      idle_step();
      k++;
      if (cnt_en) found = 1;
    end
    check_output("resume pulse found", int'(found), 1);
    check_output("resume distance", k, 3);

    // mid-run clear with start in the same cycle
    $display("[TB] mid-run clear");
    apply_stimulus(0, 0, 1, 0, 2'd0, 8'd20);
    idle_step();
    apply_stimulus(1, 0, 0, 0, 2'd0, 8'd20);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle_step();
      if (count == 8'd7) found = 1;
    end
    check_output("reached count 7", int'(found), 1);
    apply_stimulus(1, 0, 1, 0, 2'd0, 8'd20);
    check_output("clear state", int'(state), 1);
    check_output("clear cnt_clr_n", int'(cnt_clr_n), 0);
    check_output("clear busy", int'(busy), 0);
    idle_step();
    check_output("after clear state", int'(state), 0);
    check_output("after clear count", int'(count), 0);
    check_output("after clear busy", int'(busy), 0);

    // limit 0 one-shot, twice
    $display("[TB] limit 0 one-shot");
    nen = 0;
    for (int rep = 0; rep < 2; rep++) begin
      apply_stimulus(1, 0, 0, 0, 2'd0, 8'd0);
      if (cnt_en) nen++;
      check_output($sformatf("lim0 run%0d clear", rep), int'(state), 1);
      idle_step();
      if (cnt_en) nen++;
      check_output($sformatf("lim0 run%0d run", rep), int'(state), 2);
      idle_step();
      if (cnt_en) nen++;
      check_output($sformatf("lim0 run%0d done", rep), int'(state), 4);
      check_output($sformatf("lim0 run%0d done flag", rep), int'(done), 1);
    end
    check_output("lim0 no enables", nen, 0);
    check_output("lim0 count", int'(count), 0);

    // asynchronous reset in RUN
    $display("[TB] asynchronous reset mid-run");
    apply_stimulus(1, 0, 0, 0, 2'd0, 8'd20);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle_step();
      if (count == 8'd4) found = 1;
    end
    check_output("reached count 4", int'(found), 1);
    #1 clr = 1'b0;
    #1;
    check_output("async state", int'(state), 0);
    check_output("async cnt_en", int'(cnt_en), 0);
    check_output("async cnt_clr_n", int'(cnt_clr_n), 0);
    check_output("async busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    #1;
    check_output("post-reset cnt_clr_n", int'(cnt_clr_n), 1);
    @(negedge clk);
    idle_step();
    check_output("post-reset state", int'(state), 0);
    check_output("post-reset count", int'(count), 0);

    // randomized pulses and settings against the model
    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      bit       s;
      bit       p;
      bit       c;
      bit       w;
      bit [1:0] r;
      bit [7:0] l;
      w = wrap;
      r = rate_sel;
      l = limit;
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) w = ~w;
      if ($urandom_range(0, 49) == 0) r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) l = 8'($urandom_range(0, 12));
      apply_stimulus(s, p, c, w, r, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller for the 8-bit display counter. It sequences the counter's enable and clear inputs. A rate divider generates count ticks at one of four selectable rates. An FSM provides start/pause/resume/clear control and terminates or wraps at a programmable limit. It sits between the board's debounced key/switch front end and the counter; the counter's 8-bit value is fed back for limit comparison.

Parameters:
DIV_W, 26, width of the rate-divider down-counter
DIV1, 49_999_999, reload value for rate_sel=1 (tick every DIV1+1 clk cycles)
DIV2, 24_999_999, reload value for rate_sel=2
DIV3, 12_499_999, reload value for rate_sel=3

Ports:
clk  in  1  system clock, rising-edge
clr  in  1  asynchronous active-low reset
start  in  1  one-cycle synchronous pulse: start or resume
stop  in  1  one-cycle synchronous pulse: pause
clear_req  in  1  one-cycle synchronous pulse: clear counter, go idle
wrap  in  1  1 = restart from 0 after limit; 0 = one-shot, stop at limit
rate_sel  in  2  0 = tick every clk, 1..3 = DIV1..DIV3
limit  in  8  terminal count value
count  in  8  current counter value (feedback)
cnt_en  out  1  counter advances by 1 on the next clk rising edge when high
cnt_clr_n  out  1  active-low clear to counter; glitch-free
busy  out  1  high in RUN or PAUSE
done  out  1  high in DONE
state  out  3  current FSM state (debug)

Behaviour:
- Reset (clr low): state=IDLE, cnt_en=0, busy=0, done=0, divider=0. cnt_clr_n = clr AND clr_pulse_n_reg, so it is held low throughout reset and the counter clears with the controller.
- All outputs except the reset term of cnt_clr_n are registered. No combinational path from inputs to outputs.
- States (3-bit): IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4. Codes 5-7 go to IDLE.
- CLEAR lasts exactly one cycle with cnt_clr_n=0. A 1-bit next_run register records the exit: 1 goes to RUN, 0 goes to IDLE.
- Input priority each cycle: clear_req > stop > start.
- IDLE: start goes to CLEAR (next_run=1). clear_req goes to CLEAR (next_run=0).
- RUN:
  - The divider reloads to the selected value on RUN entry from CLEAR.
  - The divider decrements each cycle. At 0 it generates a tick and reloads. rate_sel=0 ticks every cycle.
  - On a tick with count != limit: cnt_en=1 for exactly that cycle.
  - On a tick with count == limit and wrap=0: go to DONE, no cnt_en.
  - On a tick with count == limit and wrap=1: go to CLEAR (next_run=1). The sequence is limit, 0, 1, ...
  - stop goes to PAUSE. clear_req goes to CLEAR (next_run=0).
- PAUSE: divider holds its value and cnt_en=0. start returns to RUN without reloading the divider. clear_req goes to CLEAR (next_run=0).
- DONE: cnt_en=0 and count holds. start goes to CLEAR (next_run=1). clear_req goes to CLEAR (next_run=0). stop is ignored.
- Edge cases:
  - limit=0, one-shot: the first tick goes to DONE with zero increments.
  - limit=0, wrap: count stays 0 with a clear pulse every tick.
  - A limit or rate_sel change mid-run takes effect at the next tick or reload respectively.
  - If count > limit (limit lowered mid-run), counting continues up to 255, wraps to 0 through the counter, then reaches limit.
  - start while busy has no effect.
  - Simultaneous start+stop in RUN: stop wins.
  - clear_req in CLEAR: next_run is forced to 0.
- Asynchronous clr mid-operation: immediate return to reset values.

Decomposition:
- Package counter_seq_pkg: state codes (ST_IDLE..ST_DONE) and rate_sel codes.
- Sub-module rate_divider holds the down-counter with reload and hold:
  - Inputs: clk, clr, load, hold, reload_val[DIV_W-1:0].
  - Output: tick.
- counter_sequencer instantiates one rate_divider plus the FSM and the limit compare.

Test Plan:
1. rate_sel=0, wrap=0, limit=5, counter model attached, pulse start. CLEAR for 1 cycle, then cnt_en high for 5 consecutive cycles, count reaches 5, then DONE, done=1. Count stays 5 for 20 cycles.
2. rate_sel=0, wrap=1, limit=3. Observed count sequence is 0,1,2,3,0,1,2,3, with one cnt_clr_n low cycle each time count=3.
3. DIV1 overridden to 3, rate_sel=1, limit=10. cnt_en pulses every 4 cycles. stop after the 2nd pulse gives PAUSE with no pulses for 10 cycles. start resumes, and the next pulse arrives at the remaining divider distance, not a full reload.
4. Mid-run clear_req with count=7 gives cnt_clr_n low 1 cycle, count=0, state IDLE, busy=0. Same cycle with start asserted: clear_req wins.
5. limit=0, wrap=0, start: DONE after first tick and cnt_en never asserted. Then start again: CLEAR, then RUN, then DONE again.
6. Assert clr low in RUN at count=4: state=IDLE, cnt_en=0 and cnt_clr_n=0 immediately, asynchronously. Release clr: cnt_clr_n=1 and the FSM idles.
